fetch_unit: RTL

- Front end of the CPU, directly upstream of instruction_memory.
- Owns the program counter and drives the memory address. Registers the returned word into an instruction register for the decode/execute stage.
- Handles redirects from JMP and ATC instructions, with a one-bubble squash on every taken redirect.
- Edge-detects and latches the external attention sources (push/pop/add/mult buttons, ALU overflow) that ATC instructions poll.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_atc_latch.sv | 37 +++
 rtl/fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch front end: widths, NOP encoding,
// attention bit indices and the fetch-action encoding used by fetch_unit.
package fetch_unit_pkg;

    localparam int CPU_ADDR_W  = 8;
    localparam int CPU_INSTR_W = 32;
    localparam int CPU_N_ATC   = 8;

    localparam logic [CPU_INSTR_W-1:0] NOP = '0;

    // Attention sources polled by ATC instructions, by bit position.
    typedef enum logic [2:0] {
        ATC_PUSH = 3'd0,
        ATC_POP  = 3'd1,
        ATC_ADD  = 3'd2,
        ATC_MULT = 3'd3,
        ATC_OFLW = 3'd4
    } atc_bit_e;

    typedef enum logic [1:0] {
        FETCH_HOLD,
        FETCH_SEQ,
        FETCH_JUMP,
        FETCH_ATC
    } fetch_act_e;

endpackage

// File: rtl/fetch_unit_atc_latch.sv
// Attention latch: rising-edge detect on each attention level plus a
// sticky pending bit that the fetch unit clears when an ATC consumes it.
module atc_latch #(
    parameter int N_ATC = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_ATC-1:0] atc_in,
    input  logic [N_ATC-1:0] clr,
    output logic [N_ATC-1:0] pending
);

    logic [N_ATC-1:0] prev_q, prev_d;
    logic [N_ATC-1:0] pending_q, pending_d;
    logic [N_ATC-1:0] rise;

    // A rise landing on the same edge as a clear wins, so no event is lost.
    always_comb begin
        rise      = atc_in & ~prev_q;
        prev_d    = atc_in;
        pending_d = (pending_q & ~clr) | rise;
    end

    // History loads the live levels during reset so held levels raise nothing.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q    <= atc_in;
            pending_q <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/fetch_unit.sv
// CPU fetch front end: owns the PC, registers the fetched word into ir, and
// squashes one slot on every taken JMP/ATC redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int INSTR_W = CPU_INSTR_W,
    parameter int N_ATC   = CPU_N_ATC
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc,
    input  logic               jump_req,
    input  logic               atc_req,
    input  logic [2:0]         atc_sel,
    input  logic [ADDR_W-1:0]  target,
    input  logic [N_ATC-1:0]   atc_in,
    output logic [N_ATC-1:0]   atc_pending,
    output logic               atc_taken
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [N_ATC-1:0]   atc_clr;
    fetch_act_e         act;

    atc_latch #(
        .N_ATC (N_ATC)
    ) u_atc_latch (
        .clock   (clock),
        .reset   (reset),
        .atc_in  (atc_in),
        .clr     (atc_clr),
        .pending (atc_pending)
    );

    // Bubbles never redirect; a jump outranks an ATC and leaves the pending bit alone.
    always_comb begin
        atc_taken = atc_req & atc_pending[atc_sel];
        act       = FETCH_HOLD;
        if (enable) begin
            if (ir_valid_q && jump_req) begin
                act = FETCH_JUMP;
            end else if (ir_valid_q && atc_taken) begin
                act = FETCH_ATC;
            end else begin
                act = FETCH_SEQ;
            end
        end
    end

    always_comb begin
        atc_clr = '0;
        if (act == FETCH_ATC) begin
            atc_clr = {{(N_ATC-1){1'b0}}, 1'b1} << atc_sel;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        case (act)
            FETCH_SEQ: begin
                pc_d       = pc_q + ADDR_W'(1);
                ir_d       = instruction;
                ir_valid_d = 1'b1;
            end
            FETCH_JUMP, FETCH_ATC: begin
                // The word fetched at the old pc is dropped: one bubble.
                pc_d       = target;
                ir_d       = INSTR_W'(NOP);
                ir_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= '0;
            ir_q       <= INSTR_W'(NOP);
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign address  = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;

endmodule
